// File: rtl/id_sb_pkg.sv
// Shared constants and the source-operand hazard rule for the ID-stage register scoreboard.
package id_sb_pkg;

  localparam int unsigned LAT_W_DEF = 3;
  // All-ones latency code marks a variable-latency (mul/div) result.
  localparam logic [LAT_W_DEF-1:0] LAT_LONG = '1;

  // An operand consumed in ID needs the result already forwardable (cnt==0);
  // one consumed in EX can tolerate a result that becomes ready next cycle (cnt<=1).
  function automatic logic src_hazard(input logic use_src, input int unsigned addr,
                                      input int unsigned cnt, input logic early);
    return use_src && (addr != 0) && (cnt > (early ? 32'd0 : 32'd1));
  endfunction

endpackage

// File: rtl/sb_entry.sv
// Latency counter for one architectural register: load on issue, count down,
// or park at the long code until the variable-latency unit reports completion.
module sb_entry #(
  parameter int LAT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic [LAT_W-1:0] lat_i,
  input  logic             done_i,
  output logic [LAT_W-1:0] cnt_o
);

  localparam logic [LAT_W-1:0] LONG = '1;

  logic [LAT_W-1:0] cnt_d, cnt_q;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i)              cnt_d = '0;
    else if (load_i)          cnt_d = lat_i;
    else if (cnt_q == LONG)   cnt_d = done_i ? '0 : cnt_q;
    else if (cnt_q != '0)     cnt_d = cnt_q - 1'b1;
  end

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/id_scoreboard.sv
// ID-stage scoreboard: per-register pending-latency counters, issue stall
// generation and a saturating stall-cycle counter.
module id_scoreboard
  import id_sb_pkg::*;
#(
  parameter  int NREG  = 32,
  parameter  int LAT_W = LAT_W_DEF,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             issue_valid_i,
  input  logic [AW-1:0]    issue_rs_i,
  input  logic [AW-1:0]    issue_rt_i,
  input  logic             issue_use_rs_i,
  input  logic             issue_use_rt_i,
  input  logic             issue_early_i,
  input  logic             issue_we_i,
  input  logic [AW-1:0]    issue_waddr_i,
  input  logic [LAT_W-1:0] issue_lat_i,
  input  logic             long_done_i,
  input  logic [AW-1:0]    long_waddr_i,
  input  logic             flush_all_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             long_busy_o,
  output logic [31:0]      stall_cnt_o
);

  localparam logic [LAT_W-1:0] LONG = '1;

  logic [LAT_W-1:0] cnt [NREG];
  logic             accept;
  logic             rs_haz, rt_haz, waw, long_conf;
  logic [31:0]      stall_cnt_d, stall_cnt_q;

  assign cnt[0] = '0;

  // NOTE: each counter resets individually because a stale pending count would stall a reader forever.
  for (genvar r = 1; r < NREG; r++) begin : g_entry
    sb_entry #(.LAT_W(LAT_W)) u_entry (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_all_i),
      .load_i  (accept && issue_we_i && (issue_waddr_i == AW'(r))),
      .lat_i   (issue_lat_i),
      .done_i  (long_done_i && (long_waddr_i == AW'(r))),
      .cnt_o   (cnt[r])
    );
  end

  always_comb begin
    busy_o      = 1'b0;
    long_busy_o = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      busy_o      = busy_o      | (cnt[r] != '0);
      long_busy_o = long_busy_o | (cnt[r] == LONG);
    end
  end

  always_comb begin
    rs_haz    = src_hazard(issue_use_rs_i, 32'(issue_rs_i), 32'(cnt[issue_rs_i]), issue_early_i);
    rt_haz    = src_hazard(issue_use_rt_i, 32'(issue_rt_i), 32'(cnt[issue_rt_i]), issue_early_i);
    waw       = issue_we_i && (issue_waddr_i != '0) && (cnt[issue_waddr_i] == LONG);
    // Only one variable-latency op may be in flight at a time.
    long_conf = issue_we_i && (issue_lat_i == LONG) && long_busy_o;
    stall_o   = issue_valid_i && (rs_haz || rt_haz || waw || long_conf);
    accept    = issue_valid_i && !stall_o && !flush_all_i;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: hazard stalls, long-op tracking, flush,
// reset and stall counter saturation, checked with immediate assertions.
module tb_id_scoreboard;

  localparam int NREG  = 32;
  localparam int LAT_W = 3;
  localparam int AW    = 5;
  localparam logic [LAT_W-1:0] LONG = 3'd7;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid;
  logic [AW-1:0]    issue_rs, issue_rt;
  logic             issue_use_rs, issue_use_rt;
  logic             issue_early;
  logic             issue_we;
  logic [AW-1:0]    issue_waddr;
  logic [LAT_W-1:0] issue_lat;
  logic             long_done;
  logic [AW-1:0]    long_waddr;
  logic             flush_all;
  logic             stall, busy, long_busy;
  logic [31:0]      stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_scoreboard #(.NREG(NREG), .LAT_W(LAT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .issue_valid_i  (issue_valid),
    .issue_rs_i     (issue_rs),
    .issue_rt_i     (issue_rt),
    .issue_use_rs_i (issue_use_rs),
    .issue_use_rt_i (issue_use_rt),
    .issue_early_i  (issue_early),
    .issue_we_i     (issue_we),
    .issue_waddr_i  (issue_waddr),
    .issue_lat_i    (issue_lat),
    .long_done_i    (long_done),
    .long_waddr_i   (long_waddr),
    .flush_all_i    (flush_all),
    .stall_o        (stall),
    .busy_o         (busy),
    .long_busy_o    (long_busy),
    .stall_cnt_o    (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_use_rs = 0; issue_use_rt = 0;
    issue_early = 0; issue_we = 0; issue_waddr = 0; issue_lat = 0;
    long_done = 0; long_waddr = 0; flush_all = 0;
  endtask

  task automatic writer(input logic [AW-1:0] wa, input logic [LAT_W-1:0] lat);
    idle();
    issue_valid = 1; issue_we = 1; issue_waddr = wa; issue_lat = lat;
  endtask

  task automatic reader(input logic use_rs, input logic [AW-1:0] rs,
                        input logic use_rt, input logic [AW-1:0] rt, input logic early);
    idle();
    issue_valid = 1; issue_use_rs = use_rs; issue_rs = rs;
    issue_use_rt = use_rt; issue_rt = rt; issue_early = early;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    check("reset_busy", 32'(busy), 0);
    check("reset_long_busy", 32'(long_busy), 0);
    check("reset_stall_cnt", stall_cnt, 0);
    check("reset_stall", 32'(stall), 0);

    // Load-use on r5 with latency 2: one stall cycle.
    writer(5, 2); #1;
    check("w5_no_stall", 32'(stall), 0);
    tick();
    reader(1, 5, 0, 0, 0); #1;
    check("ld_use_stall", 32'(stall), 1);
    check("ld_use_busy", 32'(busy), 1);
    tick();
    check("ld_use_release", 32'(stall), 0);
    check("stall_cnt_1", stall_cnt, 1);
    tick();

    // Reload r5 with 3 right after lat=2: reload wins over decrement.
    writer(5, 2); tick();
    writer(5, 3); #1;
    check("reload_accept", 32'(stall), 0);
    tick();
    reader(1, 5, 0, 0, 0); #1;
    check("reload_stall_a", 32'(stall), 1);
    tick();
    check("reload_stall_b", 32'(stall), 1);
    tick();
    check("reload_release", 32'(stall), 0);
    tick();

    // Branch (early) on r8 with latency 1 stalls once; EX consumer does not.
    writer(8, 1); tick();
    reader(0, 0, 1, 8, 1); #1;
    check("early_stall", 32'(stall), 1);
    tick();
    check("early_release", 32'(stall), 0);
    tick();
    writer(8, 1); tick();
    reader(0, 0, 1, 8, 0); #1;
    check("late_no_stall", 32'(stall), 0);
    check("stall_cnt_4", stall_cnt, 4);
    tick();

    // Writes to r0 never mark anything pending; r0 reads never stall.
    writer(0, 3); tick();
    idle(); #1;
    check("r0_write_busy", 32'(busy), 0);
    writer(6, 4); tick();
    reader(1, 0, 1, 0, 1); #1;
    check("r0_read_no_stall", 32'(stall), 0);
    check("r6_busy", 32'(busy), 1);
    tick();
    idle();
    tick(); tick(); tick();
    check("r6_drained", 32'(busy), 0);

    // Long op on r3.
    writer(3, LONG); #1;
    check("long_issue_ok", 32'(stall), 0);
    tick();
    check("long_busy_set", 32'(long_busy), 1);
    writer(10, LONG);
    long_done = 1; long_waddr = 4;
    #1;
    check("second_long_stall", 32'(stall), 1);
    tick();
    writer(3, 2); #1;
    check("waw_stall", 32'(stall), 1);
    check("done_wrong_reg_ignored", 32'(long_busy), 1);
    tick();
    reader(1, 3, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin long_done = 1; long_waddr = 3; end
      #1;
      check($sformatf("long_wait_%0d", i), 32'(stall), 1);
      tick();
    end
    long_done = 0; #1;
    check("long_release", 32'(stall), 0);
    check("long_busy_clear", 32'(long_busy), 0);
    check("stall_cnt_16", stall_cnt, 16);
    tick();

    // Flush clears all pending state and blocks the issue that cycle.
    writer(7, 4); tick();
    writer(9, LONG); tick();
    idle(); #1;
    check("pre_flush_busy", 32'(busy), 1);
    check("pre_flush_long", 32'(long_busy), 1);
    writer(11, 3); flush_all = 1;
    tick();
    idle(); #1;
    check("flush_busy", 32'(busy), 0);
    check("flush_long", 32'(long_busy), 0);
    reader(1, 9, 1, 7, 1); #1;
    check("flush_no_stall", 32'(stall), 0);
    tick();

    // Saturation: preload the stall counter near the top while stalled.
    writer(3, LONG); tick();
    reader(1, 3, 0, 0, 0);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    #1;
    check("preload", stall_cnt, 32'hFFFF_FFFD);
    tick();
    check("sat_fe", stall_cnt, 32'hFFFF_FFFE);
    tick();
    check("sat_ff", stall_cnt, 32'hFFFF_FFFF);
    tick(); tick();
    check("sat_hold", stall_cnt, 32'hFFFF_FFFF);

    // Reset mid long op discards it.
    idle();
    rst = 1; long_done = 1; long_waddr = 3;
    tick();
    rst = 0; idle(); #1;
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_long_busy", 32'(long_busy), 0);
    reader(1, 3, 0, 0, 0); #1;
    check("rst_reader_free", 32'(stall), 0);
    tick();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
ID_SCOREBOARD -- requirements
Module: id_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural registers (register 0 hard-wired zero).
REQ-002 SHALL have parameter LAT_W, default 3, width of per-register latency counter; LAT_LONG = all-ones value means unbounded latency.
REQ-003 SHALL have derived parameter AW = $clog2(NREG), register address width.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 issue_valid_i  input  1  instruction present in ID.
REQ-007 issue_rs_i, issue_rt_i  input  AW each  source register addresses.
REQ-008 issue_use_rs_i, issue_use_rt_i  input  1 each  source actually read.
REQ-009 issue_early_i  input  1  operands consumed in ID (branch/jr/jalr compare).
REQ-010 issue_we_i  input  1  instruction writes a register.
REQ-011 issue_waddr_i  input  AW  destination register.
REQ-012 issue_lat_i  input  LAT_W  cycles until result forwardable; LAT_LONG = variable (mul/div).
REQ-013 long_done_i  input  1  variable-latency unit result now forwardable.
REQ-014 long_waddr_i  input  AW  destination of completing long result.
REQ-015 flush_all_i  input  1  exception/eret pipeline flush.
REQ-016 stall_o  output  1  hold ID instruction this cycle.
REQ-017 busy_o  output  1  any register pending.
REQ-018 long_busy_o  output  1  a LAT_LONG write is outstanding.
REQ-019 stall_cnt_o  output  32  saturating count of stalled cycles.

Function
REQ-020 SHALL hold one LAT_W-bit counter cnt[r] per register r=1..NREG-1; cnt[0] SHALL read 0 always.
REQ-021 Issue accepted = issue_valid_i & ~stall_o & ~flush_all_i.
REQ-022 On accepted issue with issue_we_i and issue_waddr_i!=0, cnt[waddr] SHALL load issue_lat_i next cycle.
REQ-023 Each cycle every counter with 0<cnt<LAT_LONG not being loaded SHALL decrement by 1.
REQ-024 Counter at LAT_LONG SHALL hold until long_done_i with long_waddr_i matching, then become 0 next cycle.
REQ-025 Source hazard per operand: use=1, addr!=0, and cnt[addr] > (issue_early_i ? 0 : 1).
REQ-026 stall_o SHALL be combinational: issue_valid_i & (rs hazard | rt hazard | WAW | long conflict).
REQ-027 WAW: issue_we_i, waddr!=0, cnt[waddr]==LAT_LONG -> stall.
REQ-028 Long conflict: issue_lat_i==LAT_LONG & issue_we_i & long_busy_o -> stall (one long op in flight).
REQ-029 Simultaneous issue load and decrement/long_done on same register: issue load SHALL win.
REQ-030 long_done_i for a register not at LAT_LONG SHALL be ignored.
REQ-031 flush_all_i SHALL clear all counters to 0 next cycle and block acceptance that cycle.
REQ-032 busy_o = OR(cnt!=0); long_busy_o = OR(cnt==LAT_LONG); both registered-state derived, no input dependence.
REQ-033 stall_cnt_o SHALL increment each cycle stall_o=1, saturate at 32'hFFFF_FFFF.

Reset
REQ-034 rst_i SHALL clear all counters and stall_cnt_o to 0; busy_o=0, long_busy_o=0 the cycle after.
REQ-035 rst_i SHALL take priority over flush_all_i, issue and long_done_i; reset mid long op discards it.

Structure
REQ-036 LAT_W default, LAT_LONG and a hazard-check function SHALL live in shared package id_sb_pkg.
REQ-037 Per-register counter logic SHALL be sub-module sb_entry, generated NREG-1 times.

Verification
REQ-038 Issue we=1, waddr=5, lat=2; next cycle issue use_rs, rs=5, early=0 -> stall_o=1 one cycle, then 0.
REQ-039 Issue waddr=8, lat=1; next cycle branch early=1 rt=8 -> stall_o=1 one cycle; same with early=0 -> stall_o=0.
REQ-040 Issue waddr=3 lat=LAT_LONG; reader of r3 stalls 10 cycles until long_done_i waddr=3, then stall_o=0 next cycle; second LAT_LONG issue during wait stalls.
REQ-041 Reader rs=0 with any pending state -> stall_o=0; write to waddr=0 -> busy_o stays 0.
REQ-042 Pending lat=4 on r7 plus LAT_LONG on r9, assert flush_all_i -> next cycle busy_o=0, long_busy_o=0, no stalls.
REQ-043 Force 2^32+5 stall cycles (or preload) -> stall_cnt_o holds FFFF_FFFF; rst_i -> 0.
